// File: rtl/util_uart_pkg.sv
// Shared UART definitions: serializer FSM states and parity selection codes.
package util_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/util_axis_uart_tx.sv
// AXI-stream to UART serializer. A one-word holding register sits between the
// stream handshake and the shift register so the next word can be queued while
// a frame is on the line, letting frames run back-to-back.
module util_axis_uart_tx
  import util_uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_ENA  = 0,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 uart_clk,
  input  logic                 uart_rst,
  input  logic                 baud_ena,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BIT_CNT_W  = $clog2(DATA_BITS);
  localparam int STOP_CNT_W = $clog2(STOP_BITS + 1);

  uart_state_e             state_q, state_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    tready_q, tready_d;
  logic                    hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0]    hold_q, hold_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic                    par_q, par_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [STOP_CNT_W-1:0]   stop_cnt_q, stop_cnt_d;
  logic                    pull;

  // Parity of a full data word; odd parity is the inverted XOR reduction.
  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ logic'(PARITY_TYPE == PARITY_ODD);
  endfunction

  // Next-state logic: stream handshake, word pull and bit sequencing on baud ticks.
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    pull        = 1'b0;

    // tready mirrors an empty holding register, so accept and pull never coincide.
    if (s_axis_tvalid && tready_q) begin
      hold_full_d = 1'b1;
      hold_d      = s_axis_tdata;
    end

    if (baud_ena) begin
      case (state_q)
        ST_IDLE: begin
          if (hold_full_q) pull = 1'b1;
        end
        ST_START: begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
            if (PARITY_ENA != 0) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = '0;
              state_d    = ST_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
        ST_PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = '0;
          state_d    = ST_STOP;
        end
        ST_STOP: begin
          if (stop_cnt_q == STOP_CNT_W'(STOP_BITS - 1)) begin
            if (hold_full_q) begin
              pull = 1'b1;
            end else begin
              tx_d    = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + STOP_CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Moving the held word into the shift register starts a new frame.
    if (pull) begin
      hold_full_d = 1'b0;
      shift_d     = hold_q;
      par_d       = frame_parity(hold_q);
      tx_d        = 1'b0;
      busy_d      = 1'b1;
      state_d     = ST_START;
    end

    tready_d = ~hold_full_d;
  end

  // Control registers: reset returns the line to idle and flushes the holding slot.
  always_ff @(posedge uart_clk) begin
    if (uart_rst) begin
      state_q     <= ST_IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      tready_q    <= 1'b0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      tready_q    <= tready_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
    end
  end

  // Data registers: contents only matter while the matching flag/state says so.
  always_ff @(posedge uart_clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign s_axis_tready = tready_q;
  assign tx            = tx_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_util_axis_uart_tx.sv
// Bench for util_axis_uart_tx: four configurations (8N1, 8E1, 8O1, 8N2) share
// clock, reset, baud strobe and tdata; each has its own tvalid.
`timescale 1ns/1ps
module tb_util_axis_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_ena = 1'b0;
  logic       baud_stuck = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic [3:0] tvalid = 4'b0000;
  wire  [3:0] tready;
  wire  [3:0] txw;
  wire  [3:0] busy;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #50 clk = ~clk;

  util_axis_uart_tx #(.DATA_BITS(8), .PARITY_ENA(0), .PARITY_TYPE(0), .STOP_BITS(1)) u_8n1 (
    .uart_clk(clk), .uart_rst(rst), .baud_ena(baud_ena), .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]), .tx(txw[0]), .busy(busy[0]));
  util_axis_uart_tx #(.DATA_BITS(8), .PARITY_ENA(1), .PARITY_TYPE(0), .STOP_BITS(1)) u_8e1 (
    .uart_clk(clk), .uart_rst(rst), .baud_ena(baud_ena), .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]), .tx(txw[1]), .busy(busy[1]));
  util_axis_uart_tx #(.DATA_BITS(8), .PARITY_ENA(1), .PARITY_TYPE(1), .STOP_BITS(1)) u_8o1 (
    .uart_clk(clk), .uart_rst(rst), .baud_ena(baud_ena), .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid[2]), .s_axis_tready(tready[2]), .tx(txw[2]), .busy(busy[2]));
  util_axis_uart_tx #(.DATA_BITS(8), .PARITY_ENA(0), .PARITY_TYPE(0), .STOP_BITS(2)) u_8n2 (
    .uart_clk(clk), .uart_rst(rst), .baud_ena(baud_ena), .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid[3]), .s_axis_tready(tready[3]), .tx(txw[3]), .busy(busy[3]));

  typedef struct {
    int          inst;
    logic [7:0]  data;
    logic [15:0] frame;   // bit k = k-th bit on the line
    int          nbits;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs change 1ns after the edge; accepted beats drop tvalid and scramble tdata.
  task automatic step();
    logic [3:0] hs;
    hs = tvalid & tready & {4{~rst}};
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        tvalid[i] = 1'b0;
        tdata     = 8'hE7;
      end
    end
    cyc++;
    baud_ena = baud_stuck ? 1'b1 : ((cyc % 10) == 0);
  endtask

  task automatic push(input int inst, input logic [7:0] d, input string name);
    int w;
    tvalid[inst] = 1'b1;
    tdata = d;
    w = 0;
    while (tvalid[inst] && w < 300) begin
      step();
      w++;
    end
    check({name, " accept"}, (w < 300), 1);
    check({name, " tready_low"}, tready[inst], 1'b0);
  endtask

  task automatic capture(input int inst, input logic [15:0] exp, input int n, input int per,
                         input bit idle_after, input string name, output int waited);
    int w;
    int bad;
    w = 0;
    while (txw[inst] !== 1'b0 && w < 400) begin
      step();
      w++;
    end
    waited = w;
    check({name, " start_seen"}, (w < 400), 1);
    if (w >= 400) return;
    check({name, " tready_after_pull"}, tready[inst], 1'b1);
    for (int k = 0; k < n; k++) begin
      bad = 0;
      for (int c = 0; c < per; c++) begin
        if (txw[inst] !== exp[k] || busy[inst] !== 1'b1) bad++;
        step();
      end
      check($sformatf("%s bit%0d", name, k), bad, 0);
    end
    if (idle_after) check({name, " end_idle"}, {busy[inst], txw[inst]}, 2'b01);
    else            check({name, " next_start"}, {busy[inst], txw[inst]}, 2'b10);
  endtask

  initial begin
    int w;
    int bad;

    vecs[0] = '{0, 8'hA5, 16'({1'b1, 8'hA5, 1'b0}), 10};
    vecs[1] = '{0, 8'h00, 16'({1'b1, 8'h00, 1'b0}), 10};
    vecs[2] = '{0, 8'hFF, 16'({1'b1, 8'hFF, 1'b0}), 10};
    vecs[3] = '{1, 8'h07, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11};
    vecs[4] = '{1, 8'hFF, 16'({1'b1, 1'b0, 8'hFF, 1'b0}), 11};
    vecs[5] = '{2, 8'h07, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11};
    vecs[6] = '{3, 8'h00, 16'({2'b11, 8'h00, 1'b0}), 11};

    // Reset held with a valid beat offered: nothing may be accepted or sent.
    rst = 1'b1;
    tvalid[0] = 1'b1;
    tdata = 8'hFF;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (txw[0] !== 1'b1 || busy[0] !== 1'b0 || tready[0] !== 1'b0) bad++;
    end
    check("reset outputs", bad, 0);
    rst = 1'b0;
    tvalid[0] = 1'b0;
    step();
    check("reset tready_rise", tready, 4'b1111);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (txw !== 4'b1111 || busy !== 4'b0000) bad++;
    end
    check("reset no_frame", bad, 0);

    // Table of single frames across all configurations.
    foreach (vecs[i]) begin
      push(vecs[i].inst, vecs[i].data, $sformatf("vec%0d", i));
      capture(vecs[i].inst, vecs[i].frame, vecs[i].nbits, 10, 1'b1, $sformatf("vec%0d", i), w);
    end

    // Back-to-back: second word queued while the first is on the line.
    push(0, 8'h55, "b2b_a");
    tvalid[0] = 1'b1;
    tdata = 8'h0F;
    capture(0, 16'({1'b1, 8'h55, 1'b0}), 10, 10, 1'b0, "b2b_a", w);
    capture(0, 16'({1'b1, 8'h0F, 1'b0}), 10, 10, 1'b1, "b2b_b", w);
    check("b2b gap", w, 0);
    check("b2b tvalid_consumed", tvalid[0], 1'b0);

    // Baud strobe stuck high: one bit per clock.
    baud_stuck = 1'b1;
    baud_ena = 1'b1;
    push(0, 8'h5A, "stuck");
    capture(0, 16'({1'b1, 8'h5A, 1'b0}), 10, 1, 1'b1, "stuck", w);
    baud_stuck = 1'b0;
    baud_ena = ((cyc % 10) == 0);

    // Reset in the middle of data bit 3, with a second word waiting in the holding register.
    push(0, 8'hC3, "rstmid");
    w = 0;
    while (txw[0] !== 1'b0 && w < 400) begin
      step();
      w++;
    end
    check("rstmid start_seen", (w < 400), 1);
    for (int i = 0; i < 43; i++) step();
    tvalid[0] = 1'b1;
    tdata = 8'h99;
    step();
    check("rstmid queued", tvalid[0], 1'b0);
    rst = 1'b1;
    step();
    check("rstmid outputs", {txw[0], busy[0], tready[0]}, 3'b100);
    rst = 1'b0;
    step();
    check("rstmid tready_rise", tready[0], 1'b1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (txw[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    check("rstmid flushed", bad, 0);
    push(0, 8'h3C, "post_rst");
    capture(0, 16'({1'b1, 8'h3C, 1'b0}), 10, 10, 1'b1, "post_rst", w);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
